// File: rtl/md_pkg.sv
// Shared multiply/divide definitions: op codes used by the decoder, the MD unit
// and the issue controller, plus the issue controller's state type.
package md_pkg;

  localparam int unsigned MD_OPW = 3;

  localparam logic [MD_OPW-1:0] MD_NONE  = 3'd0;
  localparam logic [MD_OPW-1:0] MD_MULTU = 3'd1;
  localparam logic [MD_OPW-1:0] MD_DIVU  = 3'd2;
  localparam logic [MD_OPW-1:0] MD_MULT  = 3'd3;
  localparam logic [MD_OPW-1:0] MD_DIV   = 3'd4;
  localparam logic [MD_OPW-1:0] MD_MTHI  = 3'd5;
  localparam logic [MD_OPW-1:0] MD_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } md_state_e;

  // Op 7 is reserved and decodes as no request.
  function automatic logic md_is_valid(input logic [MD_OPW-1:0] op);
    return (op >= MD_MULTU) && (op <= MD_MTLO);
  endfunction

  function automatic logic md_is_div(input logic [MD_OPW-1:0] op);
    return (op == MD_DIVU) || (op == MD_DIV);
  endfunction

  function automatic logic md_is_move(input logic [MD_OPW-1:0] op);
    return (op == MD_MTHI) || (op == MD_MTLO);
  endfunction

endpackage

// File: rtl/md_issue_ctrl.sv
// E-stage issue/hazard controller for the multiply/divide unit: registers a
// one-cycle start pulse, tracks Busy, stalls on MD hazards, flags div0/watchdog.
module md_issue_ctrl #(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned OPW      = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] e_md_op,
  input  logic           e_mf,
  input  logic [31:0]    e_rs,
  input  logic [31:0]    e_rt,
  input  logic           rupt,
  input  logic           md_busy,
  output logic           md_start,
  output logic [OPW-1:0] md_op,
  output logic [31:0]    md_src1,
  output logic [31:0]    md_src2,
  output logic           stall_e,
  output logic           div0,
  output logic           wd_err,
  output logic [31:0]    issue_cnt
);
  import md_pkg::*;

  localparam int unsigned WCW = $clog2(MAX_WAIT + 1);

  md_state_e      state_q, state_d;
  logic           md_start_q, md_start_d;
  logic [OPW-1:0] md_op_q, md_op_d;
  logic [31:0]    md_src1_q, md_src1_d;
  logic [31:0]    md_src2_q, md_src2_d;
  logic           div0_q, div0_d;
  logic           wd_err_q, wd_err_d;
  logic [31:0]    issue_cnt_q, issue_cnt_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic [WCW-1:0] wait_cnt_inc;
  logic           req;

  assign req     = md_is_valid(e_md_op) || e_mf;
  assign stall_e = req && (state_q != ST_IDLE);

  always_comb begin
    state_d      = state_q;
    md_start_d   = 1'b0;
    md_op_d      = md_op_q;
    md_src1_d    = md_src1_q;
    md_src2_d    = md_src2_q;
    div0_d       = div0_q;
    wd_err_d     = wd_err_q;
    issue_cnt_d  = issue_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    wait_cnt_inc = wait_cnt_q + 1'b1;

    unique case (state_q)
      // mf in IDLE needs nothing: HI/LO are already final.
      ST_IDLE: begin
        if (md_is_valid(e_md_op) && !rupt) begin
          md_start_d = 1'b1;
          md_op_d    = e_md_op;
          md_src1_d  = e_rs;
          md_src2_d  = e_rt;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        md_op_d = '0;
        if (rupt || md_is_move(md_op_q)) begin
          state_d = ST_IDLE;
        end else begin
          state_d     = ST_WAIT;
          issue_cnt_d = issue_cnt_q + 32'd1;
          wait_cnt_d  = '0;
          if (md_is_div(md_op_q) && (md_src2_q == '0)) begin
            div0_d = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (!md_busy) begin
          state_d = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_inc;
          if (wait_cnt_inc == WCW'(MAX_WAIT)) begin
            wd_err_d = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      md_start_q  <= 1'b0;
      md_op_q     <= '0;
      md_src1_q   <= '0;
      md_src2_q   <= '0;
      div0_q      <= 1'b0;
      wd_err_q    <= 1'b0;
      issue_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      md_start_q  <= md_start_d;
      md_op_q     <= md_op_d;
      md_src1_q   <= md_src1_d;
      md_src2_q   <= md_src2_d;
      div0_q      <= div0_d;
      wd_err_q    <= wd_err_d;
      issue_cnt_q <= issue_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign md_start  = md_start_q;
  assign md_op     = md_op_q;
  assign md_src1   = md_src1_q;
  assign md_src2   = md_src2_q;
  assign div0      = div0_q;
  assign wd_err    = wd_err_q;
  assign issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl with a behavioural MD unit driving Busy and a
// scoreboard of expected start pulses.
module tb_md_issue_ctrl;
  import md_pkg::*;

  localparam int unsigned MUL_LEN = 5;
  localparam int unsigned DIV_LEN = 9;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  e_md_op;
  logic        e_mf;
  logic [31:0] e_rs, e_rt;
  logic        rupt;
  logic        md_busy;
  logic        md_start;
  logic [2:0]  md_op;
  logic [31:0] md_src1, md_src2;
  logic        stall_e, div0, wd_err;
  logic [31:0] issue_cnt;

  int unsigned ncmp  = 0;
  int unsigned nfail = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } iss_t;
  iss_t exp_q[$];

  always #5 clk = ~clk;

  md_issue_ctrl #(.MAX_WAIT(16), .OPW(3)) dut (
    .clk(clk), .reset(reset), .e_md_op(e_md_op), .e_mf(e_mf),
    .e_rs(e_rs), .e_rt(e_rt), .rupt(rupt), .md_busy(md_busy),
    .md_start(md_start), .md_op(md_op), .md_src1(md_src1), .md_src2(md_src2),
    .stall_e(stall_e), .div0(div0), .wd_err(wd_err), .issue_cnt(issue_cnt)
  );

  // MD unit model: samples the start pulse, then Busy for a fixed length.
  int unsigned busy_left;
  logic        force_busy;
  always @(posedge clk) begin
    if (reset) busy_left <= 0;
    else if (md_start && !rupt && (md_op inside {[3'd1:3'd4]}))
      busy_left <= ((md_op == MD_DIVU) || (md_op == MD_DIV)) ? DIV_LEN : MUL_LEN;
    else if (busy_left != 0) busy_left <= busy_left - 1;
  end
  assign md_busy = force_busy | (busy_left != 0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && md_start) begin
      if (exp_q.size() == 0) begin
        ncmp++;
        nfail++;
        $error("FAIL sb_unexpected: observed start op %0d expected none", md_op);
      end else begin
        iss_t e;
        e = exp_q.pop_front();
        chk("sb_op", md_op, e.op);
        chk("sb_src1", md_src1, e.a);
        chk("sb_src2", md_src2, e.b);
      end
    end
  end

  task automatic push(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    iss_t e;
    e.op = op; e.a = a; e.b = b;
    exp_q.push_back(e);
  endtask

  // Caller is in a cycle where stall_e was already seen high; counts that cycle too.
  task automatic count_stall(input string tag, input int unsigned exp_n);
    int unsigned n;
    n = 1;
    for (int unsigned i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      if (!stall_e) break;
      n++;
    end
    chk(tag, n, exp_n);
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic mf, input logic rp);
    e_md_op = op; e_rs = a; e_rt = b; e_mf = mf; rupt = rp;
  endtask

  initial begin
    reset = 1'b1; force_busy = 1'b0;
    drive(3'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_start", md_start, 0);
    chk("rst_op", md_op, 0);
    chk("rst_src1", md_src1, 0);
    chk("rst_src2", md_src2, 0);
    chk("rst_div0", div0, 0);
    chk("rst_wd", wd_err, 0);
    chk("rst_cnt", issue_cnt, 0);
    @(negedge clk); reset = 1'b0; #1;
    chk("idle_mf_nostall", stall_e, 0);

    // mult, mf held behind it
    @(negedge clk); drive(MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0); push(MD_MULT, 32'hFFFF_FFFE, 32'd3); #1;
    chk("mult_accept_nostall", stall_e, 0);
    @(negedge clk); drive(3'd0, 32'd0, 32'd0, 1'b1, 1'b0); #1;
    chk("mult_start", md_start, 1);
    chk("mult_stall_issue", stall_e, 1);
    count_stall("mult_stall_len", MUL_LEN + 2);
    chk("mult_start_done", md_start, 0);
    chk("mult_op_cleared", md_op, 0);
    chk("mult_src1_hold", md_src1, 32'hFFFF_FFFE);
    chk("mult_cnt", issue_cnt, 1);
    chk("mult_wd", wd_err, 0);

    // divu with rt==0 cancelled by rupt during ISSUE
    @(negedge clk); drive(MD_DIVU, 32'd100, 32'd0, 1'b0, 1'b0); push(MD_DIVU, 32'd100, 32'd0);
    @(negedge clk); drive(3'd0, 32'd0, 32'd0, 1'b0, 1'b1); #1;
    chk("rupt_start", md_start, 1);
    @(negedge clk); drive(3'd0, 32'd0, 32'd0, 1'b1, 1'b0); #1;
    chk("rupt_mf_nostall", stall_e, 0);
    chk("rupt_cnt", issue_cnt, 1);
    chk("rupt_div0", div0, 0);

    // request coincident with rupt in IDLE is dropped
    @(negedge clk); drive(MD_DIV, 32'd1, 32'd2, 1'b0, 1'b1); #1;
    chk("rupt_req_nostall", stall_e, 0);
    @(negedge clk); drive(3'd0, 32'd0, 32'd0, 1'b0, 1'b0); #1;
    chk("rupt_req_nostart", md_start, 0);

    // reserved op 7 is no request
    @(negedge clk); drive(3'd7, 32'd1, 32'd2, 1'b0, 1'b0);
    @(negedge clk); drive(3'd0, 32'd0, 32'd0, 1'b0, 1'b0); #1;
    chk("op7_nostart", md_start, 0);

    // back-to-back divu then mult
    @(negedge clk); drive(MD_DIVU, 32'd1000, 32'd7, 1'b0, 1'b0); push(MD_DIVU, 32'd1000, 32'd7);
    @(negedge clk); drive(MD_MULT, 32'd5, 32'd6, 1'b0, 1'b0); #1;
    chk("b2b_stall_issue", stall_e, 1);
    count_stall("b2b_stall_len", DIV_LEN + 2);
    push(MD_MULT, 32'd5, 32'd6);
    @(negedge clk); drive(3'd0, 32'd0, 32'd0, 1'b1, 1'b0); #1;
    chk("b2b_second_start", md_start, 1);
    count_stall("b2b_mult_stall_len", MUL_LEN + 2);
    chk("b2b_cnt", issue_cnt, 3);
    chk("b2b_div0", div0, 0);

    // signed div by zero
    @(negedge clk); drive(MD_DIV, 32'd9, 32'd0, 1'b0, 1'b0); push(MD_DIV, 32'd9, 32'd0);
    @(negedge clk); drive(3'd0, 32'd0, 32'd0, 1'b1, 1'b0); #1;
    count_stall("div0_stall_len", DIV_LEN + 2);
    chk("div0_set", div0, 1);
    chk("div0_cnt", issue_cnt, 4);

    // mthi, then mflo stalls exactly one cycle
    @(negedge clk); drive(MD_MTHI, 32'h1234, 32'h55, 1'b0, 1'b0); push(MD_MTHI, 32'h1234, 32'h55); #1;
    chk("mthi_nostall", stall_e, 0);
    @(negedge clk); drive(3'd0, 32'd0, 32'd0, 1'b1, 1'b0); #1;
    chk("mthi_start", md_start, 1);
    chk("mflo_stall", stall_e, 1);
    @(negedge clk); #1;
    chk("mflo_released", stall_e, 0);
    chk("mthi_cnt", issue_cnt, 4);
    chk("div0_sticky", div0, 1);

    // watchdog with Busy stuck high
    @(negedge clk); force_busy = 1'b1; drive(MD_MULTU, 32'd2, 32'd3, 1'b0, 1'b0); push(MD_MULTU, 32'd2, 32'd3);
    @(negedge clk); drive(3'd0, 32'd0, 32'd0, 1'b1, 1'b0); #1;
    count_stall("wd_stall_len", 17);
    chk("wd_set", wd_err, 1);
    chk("wd_cnt", issue_cnt, 5);

    // reset mid-WAIT
    @(negedge clk); drive(MD_MULT, 32'hAAAA, 32'hBBBB, 1'b0, 1'b0); push(MD_MULT, 32'hAAAA, 32'hBBBB);
    @(negedge clk); drive(3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0; force_busy = 1'b0; e_mf = 1'b1; #1;
    chk("mid_rst_start", md_start, 0);
    chk("mid_rst_op", md_op, 0);
    chk("mid_rst_src1", md_src1, 0);
    chk("mid_rst_src2", md_src2, 0);
    chk("mid_rst_div0", div0, 0);
    chk("mid_rst_wd", wd_err, 0);
    chk("mid_rst_cnt", issue_cnt, 0);
    chk("mid_rst_nostall", stall_e, 0);

    @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/md_issue_ctrl.md
Name: md_issue_ctrl

Overview:
- Issue and hazard controller directly upstream of the multiply/divide unit in the E stage of the 5-stage MIPS core.
- Accepts decoded MD requests and operands from the E stage and registers them into a single-cycle start pulse for the MD unit.
- Tracks unit occupancy from the issue pulse until Busy falls, stalls the E stage on MD structural/HI-LO hazards, and handles interrupt cancellation, a wait watchdog and divide-by-zero flagging.

Parameters:
- MAX_WAIT, 16, maximum WAIT-state cycles before the watchdog fires (MD unit worst case is 10 + 1).
- OPW, 3, width of MD op code.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- e_md_op  in  3  E-stage request: 0 none, 1 multu, 2 divu, 3 mult, 4 div, 5 mthi, 6 mtlo, 7 reserved (treated as 0)
- e_mf  in  1  E-stage instruction is mfhi/mflo
- e_rs  in  32  forwarded rs value
- e_rt  in  32  forwarded rt value
- rupt  in  1  exception/interrupt flush, same signal the MD unit receives
- md_busy  in  1  Busy from MD unit
- md_start  out  1  registered start pulse to MD unit
- md_op  out  3  registered op to MD unit
- md_src1  out  32  registered rs
- md_src2  out  32  registered rt
- stall_e  out  1  combinational stall to E stage and upstream
- div0  out  1  sticky: div/divu issued with rt == 0
- wd_err  out  1  sticky: watchdog expired
- issue_cnt  out  32  count of mul/div ops that entered WAIT

Behaviour:
- Reset: state IDLE; md_start 0, md_op 0, md_src1/2 0, div0 0, wd_err 0, issue_cnt 0, wait counter 0. Reset overrides every other event, including mid-WAIT.
- States: IDLE, ISSUE, WAIT.
- Request present: req = (e_md_op in 1..6) | e_mf.
- stall_e = req & (state != IDLE), combinational.
- IDLE: if e_md_op in 1..6 and !rupt, capture op/rs/rt into outputs, md_start <= 1, go to ISSUE. e_mf in IDLE is accepted with no stall and no state change, since HI/LO are already final. Otherwise md_start <= 0.
- ISSUE (exactly 1 cycle, md_start = 1): MD unit samples at the closing edge. md_start <= 0, md_op <= 0 at that edge.
  - If rupt is high this cycle, the MD unit drops the op; go to IDLE, no count, no div0.
  - Else if op is 5/6 (mthi/mtlo), go to IDLE.
  - Else go to WAIT: issue_cnt += 1 (wraps at 2^32), wait counter cleared. If op is 2/4 and md_src2 == 0, set div0.
- WAIT: md_busy is high from the first WAIT cycle.
  - md_busy == 0: go to IDLE. HI/LO are updated at that same edge, so the next cycle's mf is valid.
  - Else increment wait counter. When it reaches MAX_WAIT, set wd_err and go to IDLE.
  - rupt during WAIT does not abort; the MD unit completes.
- Latency: a mul/div accepted at edge k has md_start high in cycle k+1, md_busy high from edge k+2, and stall_e deasserts the cycle after md_busy falls. Back-to-back MD ops are therefore separated by ISSUE plus the full Busy window.
- Simultaneous rupt and new request in IDLE: request is not captured and stall_e stays 0 (instruction is being flushed).
- Reserved op 7 behaves as op 0.
- Outputs md_src1/2 hold their last value outside ISSUE.

Decomposition:
- Shared package md_pkg holds:
  - MD op-code localparams: MD_NONE, MD_MULTU, MD_DIVU, MD_MULT, MD_DIV, MD_MTHI, MD_MTLO. These are reused by the decoder and the MD unit.
  - State encoding for IDLE, ISSUE, WAIT.
- No sub-module; the wait counter is inline.

Test Plan:
- mult: e_md_op = 3, rs = 0xFFFFFFFE, rt = 3 in IDLE -> md_start pulse 1 cycle with md_op = 3, md_src1 = 0xFFFFFFFE, md_src2 = 3; stall_e high through ISSUE and the 5 Busy cycles when e_mf = 1 is held; issue_cnt = 1.
- Back-to-back div: divu then mult -> second request stalls until the cycle after md_busy falls (11 cycles), then issues.
- Divide by zero: div, rt = 0 -> div0 = 1 and stays set through later ops; it clears only on reset.
- rupt during ISSUE of divu -> state returns to IDLE next cycle, issue_cnt unchanged, div0 unchanged, and the next mf is not stalled.
- Watchdog: md_busy tied high after issue -> wd_err = 1 after 16 WAIT cycles and the FSM returns to IDLE. Also assert reset mid-WAIT -> all outputs return to 0 next cycle.
- mthi, rs = 0x1234 -> one md_start pulse with md_op = 5 and no WAIT; a following mflo in the next cycle stalls for exactly 1 cycle.
